// File: rtl/eth_tx_arbiter_if.sv
// ============================================================================
// Module      : eth_tx_arbiter_if
// Description : Request/grant and TX-chain signals between the reply engines,
//               the TX header/MAC chain and the round-robin TX arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface eth_tx_arbiter_if #(
    parameter int NUM_REQ = 3
);
    localparam int c_SEL_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               frame_done;
    logic [NUM_REQ-1:0] start;
    logic               tx_start;
    logic [c_SEL_W-1:0] sel;
    logic               busy;
    logic               abort;

    modport master (
        input  req,
        input  frame_done,
        output start,
        output tx_start,
        output sel,
        output busy,
        output abort
    );

    modport slave (
        output req,
        output frame_done,
        input  start,
        input  tx_start,
        input  sel,
        input  busy,
        input  abort
    );
endinterface

`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
// ============================================================================
// Module      : eth_tx_arbiter
// Description : Round-robin scheduler sharing the Ethernet TX path between
//               protocol reply engines, with an enforced inter-frame gap.
//               Optional ACTIVE watchdog enabled by ETH_TX_ARB_WATCHDOG_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module eth_tx_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int GAP_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic          aclk,
    input  wire logic          areset,
    eth_tx_arbiter_if.master   bus
);

    localparam int c_SEL_W = $clog2(NUM_REQ);
    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_ACTIVE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_start;
    logic [NUM_REQ-1:0] w_start_nxt;
    logic               r_tx_start;
    logic               w_tx_start_nxt;
    logic [c_SEL_W-1:0] r_sel;
    logic [c_SEL_W-1:0] w_sel_nxt;
    logic [c_SEL_W-1:0] r_last;
    logic [c_SEL_W-1:0] w_last_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_GAP_W-1:0] w_gap_cnt_nxt;

    logic               w_found;
    logic [c_SEL_W-1:0] w_pick;
    int                 w_best_dist;

`ifdef ETH_TX_ARB_WATCHDOG_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES);

    logic [c_WD_W-1:0]  r_wd_cnt;
    logic [c_WD_W-1:0]  w_wd_cnt_nxt;
    logic               r_abort;
    logic               w_abort_nxt;
`endif

    // Round-robin pick: the requester with the smallest forward distance from
    // the one after the last grant wins.
    always_comb begin
        w_found     = 1'b0;
        w_pick      = '0;
        w_best_dist = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] &&
                (((i + 2 * NUM_REQ - int'(r_last) - 1) % NUM_REQ) < w_best_dist)) begin
                w_best_dist = (i + 2 * NUM_REQ - int'(r_last) - 1) % NUM_REQ;
                w_pick      = c_SEL_W'(i);
                w_found     = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_start_nxt    = '0;
        w_tx_start_nxt = 1'b0;
        w_sel_nxt      = r_sel;
        w_last_nxt     = r_last;
        w_busy_nxt     = r_busy;
        w_gap_cnt_nxt  = r_gap_cnt;
`ifdef ETH_TX_ARB_WATCHDOG_EN
        w_wd_cnt_nxt   = r_wd_cnt;
        w_abort_nxt    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_GRANT;
                    w_sel_nxt      = w_pick;
                    w_last_nxt     = w_pick;
                    w_start_nxt    = NUM_REQ'(1) << w_pick;
                    w_tx_start_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_GRANT: begin
                w_state_nxt = S_ACTIVE;
`ifdef ETH_TX_ARB_WATCHDOG_EN
                w_wd_cnt_nxt = '0;
`endif
            end
            S_ACTIVE: begin
                if (bus.frame_done) begin
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = c_GAP_W'(GAP_CYCLES - 1);
`ifdef ETH_TX_ARB_WATCHDOG_EN
                end else if (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = c_GAP_W'(GAP_CYCLES - 1);
                    w_abort_nxt   = 1'b1;
                end else begin
                    w_wd_cnt_nxt  = r_wd_cnt + c_WD_W'(1);
`endif
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - c_GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Last-grant pointer resets to the top requester so req[0] wins first.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_start    <= '0;
            r_tx_start <= 1'b0;
            r_sel      <= '0;
            r_last     <= c_SEL_W'(NUM_REQ - 1);
            r_busy     <= 1'b0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_start    <= w_start_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_sel      <= w_sel_nxt;
            r_last     <= w_last_nxt;
            r_busy     <= w_busy_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
        end
    end

`ifdef ETH_TX_ARB_WATCHDOG_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wd_cnt <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_wd_cnt <= w_wd_cnt_nxt;
            r_abort  <= w_abort_nxt;
        end
    end

    assign bus.abort = r_abort;
`else
    // Without the watchdog TIMEOUT_CYCLES has no effect; this scope only marks
    // an out-of-range setting.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_out_of_range
    end

    assign bus.abort = 1'b0;
`endif

    assign bus.start    = r_start;
    assign bus.tx_start = r_tx_start;
    assign bus.sel      = r_sel;
    assign bus.busy     = r_busy;

endmodule

`default_nettype wire
